// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default geometry and the occupancy-width helper shared by the sync_fifo slice.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_MEM_DEPTH  = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 3;
    localparam int unsigned DEFAULT_AE_LEVEL   = 2;

    // Pointers and COUNT carry one extra wrap bit over the storage address.
    function automatic int unsigned occ_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    localparam int unsigned DEFAULT_COUNT_WIDTH = occ_width(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port word array, write-enabled write port and registered read port.
module sync_fifo_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, registered read data and status flags.
// Sticky OVERFLOW/UNDERFLOW logic exists only when SYNC_FIFO_ERR_FLAG_EN is defined.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = MEM_DEPTH - 2,
    parameter int unsigned AE_LEVEL   = DEFAULT_AE_LEVEL
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int unsigned CW = occ_width(ADDR_WIDTH);

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;
    logic          rd_valid_q;

    // Flags come straight from the registered pointers, so async reset clears them at once.
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;

    assign wr_ok = WR_EN && !full;
    assign rd_ok = RD_EN && !empty;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr       <= '0;
            rptr       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + CW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + CW'(1);
            end
            rd_valid_q <= rd_ok;
        end
    end

    sync_fifo_ram #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RST),
        .we    (wr_ok),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (WR_DATA),
        .re    (rd_ok),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (RD_DATA)
    );

    assign RD_VALID     = rd_valid_q;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign COUNT        = count;
    assign ALMOST_FULL  = (32'(count) >= AF_LEVEL);
    assign ALMOST_EMPTY = (32'(count) <= AE_LEVEL);

`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (WR_EN && full) begin
                ovf_q <= 1'b1;
            end
            if (RD_EN && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table vectors, directed corner sequences and random traffic against a queue model.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_FLAG_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] WR_DATA = '0;
    logic       WR_EN = 1'b0;
    logic       RD_EN = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
    logic [3:0] COUNT;

    sync_fifo #(
        .DATA_WIDTH (8),
        .MEM_DEPTH  (8),
        .ADDR_WIDTH (3),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR_DATA      (WR_DATA),
        .WR_EN        (WR_EN),
        .RD_EN        (RD_EN),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy is simply the queue length.
    logic [7:0] q[$];
    logic [7:0] m_data;
    bit         m_valid, m_ovf, m_unf;

    function automatic void model_clear();
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endfunction

    task automatic compare_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},  32'(COUNT),        32'(n));
        chk({tag, ".full"},   32'(FULL),         32'(n == DEPTH));
        chk({tag, ".empty"},  32'(EMPTY),        32'(n == 0));
        chk({tag, ".af"},     32'(ALMOST_FULL),  32'(n >= 6));
        chk({tag, ".ae"},     32'(ALMOST_EMPTY), 32'(n <= 2));
        chk({tag, ".valid"},  32'(RD_VALID),     32'(m_valid));
        chk({tag, ".data"},   32'(RD_DATA),      32'(m_data));
        chk({tag, ".ovf"},    32'(OVERFLOW),     32'(m_ovf));
        chk({tag, ".unf"},    32'(UNDERFLOW),    32'(m_unf));
    endtask

    task automatic step(input string tag, input bit wr, input bit rd, input logic [7:0] d);
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        WR_EN = wr; RD_EN = rd; WR_DATA = d;
        if (rd && !was_empty) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr && !was_full) q.push_back(d);
        if (wr && was_full)  m_ovf = ERR;
        if (rd && was_empty) m_unf = ERR;
        @(posedge CLK); #1;
        WR_EN = 1'b0; RD_EN = 1'b0;
        compare_all(tag);
    endtask

    task automatic do_reset();
        WR_EN = 1'b0; RD_EN = 1'b0;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        model_clear();
    endtask

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] d;
        int         cnt;
        bit         valid;
        logic [7:0] data;
        bit         ovf;
        bit         unf;
    } vec_t;

    function automatic vec_t mk(bit wr, bit rd, logic [7:0] d, int cnt, bit valid,
                                logic [7:0] data, bit ovf, bit unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.d = d; v.cnt = cnt; v.valid = valid;
        v.data = data; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected values written out from the fill/drain rules, independent of the model.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1'b1, 1'b0, 8'(8'h11 + i), i + 1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[8] = mk(1'b1, 1'b0, 8'h99, 8, 1'b0, 8'h00, ERR, 1'b0);
        for (int i = 0; i < 8; i++)
            tbl[9 + i] = mk(1'b0, 1'b1, 8'h00, 7 - i, 1'b1, 8'(8'h11 + i), ERR, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h18, ERR, ERR);

        model_clear();
        #3 RST = 1'b0;
        #1 compare_all("reset_state");
        @(posedge CLK); #1 RST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            WR_EN = tbl[i].wr; RD_EN = tbl[i].rd; WR_DATA = tbl[i].d;
            @(posedge CLK); #1;
            WR_EN = 1'b0; RD_EN = 1'b0;
            chk($sformatf("tbl%0d.count", i), 32'(COUNT),        32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.valid", i), 32'(RD_VALID),     32'(tbl[i].valid));
            chk($sformatf("tbl%0d.data", i),  32'(RD_DATA),      32'(tbl[i].data));
            chk($sformatf("tbl%0d.full", i),  32'(FULL),         32'(tbl[i].cnt == 8));
            chk($sformatf("tbl%0d.empty", i), 32'(EMPTY),        32'(tbl[i].cnt == 0));
            chk($sformatf("tbl%0d.af", i),    32'(ALMOST_FULL),  32'(tbl[i].cnt >= 6));
            chk($sformatf("tbl%0d.ae", i),    32'(ALMOST_EMPTY), 32'(tbl[i].cnt <= 2));
            chk($sformatf("tbl%0d.ovf", i),   32'(OVERFLOW),     32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.unf", i),   32'(UNDERFLOW),    32'(tbl[i].unf));
        end

        // Steady state at COUNT=3 across two pointer wraps.
        do_reset();
        for (int i = 0; i < 3; i++) step("pre3", 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            step("pair", 1'b1, 1'b1, 8'(8'h40 + i));
            chk("pair.count3", 32'(COUNT), 32'd3);
        end

        // Simultaneous request on empty, then on full.
        do_reset();
        step("empty_wr_rd", 1'b1, 1'b1, 8'h5A);
        chk("empty_wr_rd.count1", 32'(COUNT), 32'd1);
        chk("empty_wr_rd.valid0", 32'(RD_VALID), 32'd0);
        for (int i = 0; i < 7; i++) step("fill", 1'b1, 1'b0, 8'(8'h60 + i));
        step("full_wr_rd", 1'b1, 1'b1, 8'hEE);
        chk("full_wr_rd.count7", 32'(COUNT), 32'd7);
        chk("full_wr_rd.pop", 32'(RD_DATA), 32'h5A);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 8'h00);

        // Asynchronous reset mid-burst, with an error flag armed beforehand.
        do_reset();
        step("pre_unf", 1'b0, 1'b1, 8'h00);
        step("pre_ovf_fill", 1'b1, 1'b0, 8'h71);
        for (int i = 0; i < 4; i++) step("burst", 1'b1, 1'b0, 8'(8'h72 + i));
        chk("burst.count5", 32'(COUNT), 32'd5);
        #2 RST = 1'b0;
        model_clear();
        #1 compare_all("async_rst");
        @(posedge CLK); #1 RST = 1'b1;
        step("post_rst_wr", 1'b1, 1'b0, 8'hA5);
        step("post_rst_rd", 1'b0, 1'b1, 8'h00);
        chk("post_rst_rd.first", 32'(RD_DATA), 32'hA5);

        // Random traffic, biased first toward filling and then toward draining.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int wp;
            bit w, r;
            wp = (i < 200) ? 70 : 30;
            w = ($urandom_range(0, 99) < wp);
            r = ($urandom_range(0, 99) < (100 - wp));
            step("rnd", w, r, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
